// File: rtl/sync_ctrl.sv
// Receiver synchronisation loop controller: PSS search, SSS confirmation, windowed
// PSS tracking with loss-of-sync detection, and the accumulated CFO increment for the DDS.
module sync_ctrl #(
  parameter int CFO_DW      = 20,
  parameter int DDS_DW      = 20,
  parameter int SSB_PERIOD  = 38400,
  parameter int PSS_WINDOW  = 16,
  parameter int SSS_TIMEOUT = 4096,
  parameter int MAX_MISSES  = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     sample_valid_i,
  input  logic                     N_id_2_valid_i,
  input  logic [1:0]               N_id_2_i,
  input  logic                     CFO_valid_i,
  input  logic signed [CFO_DW-1:0] CFO_DDS_inc_i,
  input  logic                     N_id_valid_i,
  output logic [1:0]               PSS_detector_mode_o,
  output logic [1:0]               requested_N_id_2_o,
  output logic signed [DDS_DW-1:0] CFO_DDS_inc_o,
  output logic                     CFO_DDS_inc_valid_o,
  output logic                     locked_o,
  output logic                     lost_sync_o,
  output logic [1:0]               state_o
);

  localparam int CNT_W  = $clog2(SSB_PERIOD + PSS_WINDOW + 1);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);
  localparam int SUM_W  = ((CFO_DW > DDS_DW) ? CFO_DW : DDS_DW) + 1;

  localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(SSB_PERIOD - PSS_WINDOW);
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(SSB_PERIOD + PSS_WINDOW);
  localparam logic [CNT_W-1:0] REALIGN = CNT_W'(PSS_WINDOW);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(SSS_TIMEOUT);

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (DDS_DW - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_WAIT_SSS = 2'd1,
    ST_TRACK    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_SEARCH = 2'd0,
    MODE_OFF    = 2'd1,
    MODE_TRACK  = 2'd2
  } mode_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [MISS_W-1:0]   r_miss;

  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_in_win;
  logic                    w_inc_in_win;
  logic                    w_win_close;
  logic                    w_pss_hit;
  logic                    w_last_miss;
  logic                    w_lose;
  logic signed [SUM_W-1:0] w_cfo_diff;
  logic signed [DDS_DW-1:0] w_cfo_sat;

  assign state_o      = r_state;
  assign w_cnt_inc    = r_cnt + CNT_W'(sample_valid_i);
  assign w_in_win     = (r_cnt >= WIN_LO) && (r_cnt <= WIN_HI);
  assign w_inc_in_win = (w_cnt_inc >= WIN_LO) && (w_cnt_inc <= WIN_HI);
  assign w_win_close  = (r_cnt == WIN_HI);
  assign w_pss_hit    = N_id_2_valid_i && w_in_win;
  assign w_last_miss  = (r_miss == MISS_W'(MAX_MISSES - 1));

  // Loss of sync: SSS never confirmed in time, or the final tracking window closed empty.
  assign w_lose = ((r_state == ST_WAIT_SSS) && !N_id_valid_i && (r_cnt == TIMEOUT)) ||
                  ((r_state == ST_TRACK) && w_win_close && !w_pss_hit && w_last_miss);

  // The detector reports the offset relative to the current correction, so it is subtracted.
  assign w_cfo_diff = SUM_W'(CFO_DDS_inc_o) - SUM_W'(CFO_DDS_inc_i);

  always_comb begin
    w_cfo_sat = w_cfo_diff[DDS_DW-1:0];
    if (w_cfo_diff > SAT_MAX)      w_cfo_sat = SAT_MAX[DDS_DW-1:0];
    else if (w_cfo_diff < SAT_MIN) w_cfo_sat = SAT_MIN[DDS_DW-1:0];
  end

  // NOTE: state and outputs are flops, so every assignment here is non-blocking; the pulse
  // outputs get a default of 0 at the top so they can only last one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state             <= ST_SEARCH;
      r_cnt               <= '0;
      r_miss              <= '0;
      PSS_detector_mode_o <= MODE_SEARCH;
      requested_N_id_2_o  <= 2'd0;
      CFO_DDS_inc_o       <= '0;
      CFO_DDS_inc_valid_o <= 1'b0;
      locked_o            <= 1'b0;
      lost_sync_o         <= 1'b0;
    end else begin
      lost_sync_o         <= 1'b0;
      CFO_DDS_inc_valid_o <= 1'b0;
      r_cnt               <= w_cnt_inc;

      if (w_lose) begin
        CFO_DDS_inc_o       <= '0;
        CFO_DDS_inc_valid_o <= 1'b1;
      end else if (CFO_valid_i) begin
        CFO_DDS_inc_o       <= w_cfo_sat;
        CFO_DDS_inc_valid_o <= 1'b1;
      end

      case (r_state)
        ST_SEARCH: begin
          PSS_detector_mode_o <= MODE_SEARCH;
          if (N_id_2_valid_i) begin
            requested_N_id_2_o  <= N_id_2_i;
            r_cnt               <= '0;
            r_state             <= ST_WAIT_SSS;
            PSS_detector_mode_o <= MODE_OFF;
          end
        end

        ST_WAIT_SSS: begin
          if (N_id_valid_i) begin
            r_state             <= ST_TRACK;
            locked_o            <= 1'b1;
            r_miss              <= '0;
            PSS_detector_mode_o <= w_inc_in_win ? MODE_TRACK : MODE_OFF;
          end else if (r_cnt == TIMEOUT) begin
            r_state             <= ST_SEARCH;
            lost_sync_o         <= 1'b1;
            PSS_detector_mode_o <= MODE_SEARCH;
          end
        end

        ST_TRACK: begin
          if (w_pss_hit) begin
            r_cnt               <= '0;
            r_miss              <= '0;
            PSS_detector_mode_o <= MODE_OFF;
          end else if (w_win_close) begin
            // Restart at the window half-width so the next window stays on the nominal grid.
            r_cnt <= REALIGN;
            if (w_last_miss) begin
              r_state             <= ST_SEARCH;
              r_miss              <= '0;
              locked_o            <= 1'b0;
              lost_sync_o         <= 1'b1;
              PSS_detector_mode_o <= MODE_SEARCH;
            end else begin
              r_miss              <= r_miss + MISS_W'(1);
              PSS_detector_mode_o <= MODE_OFF;
            end
          end else begin
            PSS_detector_mode_o <= w_inc_in_win ? MODE_TRACK : MODE_OFF;
          end
        end

        default: begin
          r_state             <= ST_SEARCH;
          locked_o            <= 1'b0;
          PSS_detector_mode_o <= MODE_SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_ctrl.sv
// Self-checking bench for sync_ctrl: randomized directed phases against a behavioural model.
// The SSB period is shortened so several tracking periods fit in a short run.
module tb_sync_ctrl;

  localparam int CFO_DW      = 20;
  localparam int DDS_DW      = 20;
  localparam int SSB_PERIOD  = 4800;
  localparam int PSS_WINDOW  = 16;
  localparam int SSS_TIMEOUT = 4096;
  localparam int MAX_MISSES  = 3;
  localparam int CNT_MOD     = 1 << $clog2(SSB_PERIOD + PSS_WINDOW + 1);
  localparam int SAT         = (1 << (DDS_DW - 1)) - 1;

  localparam int S_SEARCH = 0;
  localparam int S_WAIT   = 1;
  localparam int S_TRACK  = 2;

  logic                     clk_i = 1'b0;
  logic                     reset_i;
  logic                     sample_valid_i;
  logic                     N_id_2_valid_i;
  logic [1:0]               N_id_2_i;
  logic                     CFO_valid_i;
  logic signed [CFO_DW-1:0] CFO_DDS_inc_i;
  logic                     N_id_valid_i;
  logic [1:0]               PSS_detector_mode_o;
  logic [1:0]               requested_N_id_2_o;
  logic signed [DDS_DW-1:0] CFO_DDS_inc_o;
  logic                     CFO_DDS_inc_valid_o;
  logic                     locked_o;
  logic                     lost_sync_o;
  logic [1:0]               state_o;

  sync_ctrl #(
    .CFO_DW     (CFO_DW),
    .DDS_DW     (DDS_DW),
    .SSB_PERIOD (SSB_PERIOD),
    .PSS_WINDOW (PSS_WINDOW),
    .SSS_TIMEOUT(SSS_TIMEOUT),
    .MAX_MISSES (MAX_MISSES)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .sample_valid_i     (sample_valid_i),
    .N_id_2_valid_i     (N_id_2_valid_i),
    .N_id_2_i           (N_id_2_i),
    .CFO_valid_i        (CFO_valid_i),
    .CFO_DDS_inc_i      (CFO_DDS_inc_i),
    .N_id_valid_i       (N_id_valid_i),
    .PSS_detector_mode_o(PSS_detector_mode_o),
    .requested_N_id_2_o (requested_N_id_2_o),
    .CFO_DDS_inc_o      (CFO_DDS_inc_o),
    .CFO_DDS_inc_valid_o(CFO_DDS_inc_valid_o),
    .locked_o           (locked_o),
    .lost_sync_o        (lost_sync_o),
    .state_o            (state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: sample position since the last PSS reference, plus the spec-level outputs.
  int m_state, m_pos, m_misses, m_req, m_cfo, m_cfo_vld, m_lost;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input int pos);
    return (pos >= SSB_PERIOD - PSS_WINDOW) && (pos <= SSB_PERIOD + PSS_WINDOW);
  endfunction

  function automatic int exp_mode();
    if (m_state == S_SEARCH) return 0;
    if (m_state == S_WAIT)   return 1;
    return in_window(m_pos) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_state = S_SEARCH; m_pos = 0; m_misses = 0; m_req = 0;
    m_cfo = 0; m_cfo_vld = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit pss, input int nid2, input bit cfo_v, input int cfo_in,
                            input bit nid_v, input bit sv);
    int  nxt;
    bit  lose;
    nxt  = (m_pos + int'(sv)) % CNT_MOD;
    lose = 1'b0;
    case (m_state)
      S_SEARCH: if (pss) begin
        m_req = nid2; nxt = 0; m_state = S_WAIT;
      end
      S_WAIT: if (nid_v) begin
        m_state = S_TRACK; m_misses = 0;
      end else if (m_pos == SSS_TIMEOUT) begin
        m_state = S_SEARCH; lose = 1'b1;
      end
      default: if (pss && in_window(m_pos)) begin
        nxt = 0; m_misses = 0;
      end else if (m_pos == SSB_PERIOD + PSS_WINDOW) begin
        m_misses++;
        nxt = PSS_WINDOW;
        if (m_misses >= MAX_MISSES) begin
          m_state = S_SEARCH; lose = 1'b1; m_misses = 0;
        end
      end
    endcase
    m_pos     = nxt;
    m_lost    = lose;
    m_cfo_vld = 0;
    if (lose) begin
      m_cfo = 0; m_cfo_vld = 1;
    end else if (cfo_v) begin
      m_cfo = m_cfo - cfo_in;
      if (m_cfo > SAT)  m_cfo = SAT;
      if (m_cfo < -SAT) m_cfo = -SAT;
      m_cfo_vld = 1;
    end
  endtask

  task automatic check_all();
    check("state",     state_o, m_state);
    check("mode",      PSS_detector_mode_o, exp_mode());
    check("requested", requested_N_id_2_o, m_req);
    check("cfo",       CFO_DDS_inc_o, m_cfo);
    check("cfo_valid", CFO_DDS_inc_valid_o, m_cfo_vld);
    check("locked",    locked_o, int'(m_state == S_TRACK));
    check("lost_sync", lost_sync_o, m_lost);
  endtask

  task automatic step(input bit pss = 0, input int nid2 = 0, input bit cfo_v = 0,
                      input int cfo_in = 0, input bit nid_v = 0, input bit sv = 1);
    sample_valid_i = sv;
    N_id_2_valid_i = pss;
    N_id_2_i       = nid2[1:0];
    CFO_valid_i    = cfo_v;
    CFO_DDS_inc_i  = cfo_in[CFO_DW-1:0];
    N_id_valid_i   = nid_v;
    @(posedge clk_i);
    model_step(pss, nid2, cfo_v, cfo_in, nid_v, sv);
    #1;
    check_all();
  endtask

  function automatic bit rnd_sv();
    return $urandom_range(0, 7) != 0;
  endfunction

  task automatic rnd_cfo(output bit v, output int x);
    v = ($urandom_range(0, 15) == 0);
    x = int'($urandom_range(0, 4000)) - 2000;
  endtask

  task automatic hold_reset();
    sample_valid_i = 0; N_id_2_valid_i = 0; N_id_2_i = 0;
    CFO_valid_i = 0; CFO_DDS_inc_i = 0; N_id_valid_i = 0;
    reset_i = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    check_all();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Advance with random sample gaps and CFO traffic until the model counter equals target.
  task automatic run_to_pos(input int target, input bit noise);
    int n;
    bit cv, pss;
    int ci;
    n = 0;
    while (m_pos != target && n < 3 * SSB_PERIOD) begin
      rnd_cfo(cv, ci);
      pss = noise && (m_state == S_TRACK) && (m_pos < SSB_PERIOD - PSS_WINDOW - 1) &&
            ($urandom_range(0, 200) == 0);
      step(pss, int'($urandom_range(0, 3)), cv, ci, 1'b0, rnd_sv());
      n++;
    end
    check("reach_pos", int'(m_pos == target), 1);
  endtask

  task automatic hit_at(input int offset);
    run_to_pos(SSB_PERIOD + offset, 1'b1);
    step(1'b1, int'($urandom_range(0, 3)), 1'b0, 0, 1'b0, rnd_sv());
    check("hit_keeps_track", state_o, S_TRACK);
  endtask

  task automatic timeout_phase();
    int n;
    bit seen, cv;
    int ci;
    n = 0; seen = 0;
    while (!seen && n < 2 * SSS_TIMEOUT) begin
      rnd_cfo(cv, ci);
      step($urandom_range(0, 63) == 0, int'($urandom_range(0, 3)), cv, ci, 1'b0, rnd_sv());
      if (lost_sync_o) begin
        seen = 1;
        check("timeout_state", state_o, S_SEARCH);
        check("timeout_mode",  PSS_detector_mode_o, 0);
        check("timeout_cfo",   CFO_DDS_inc_o, 0);
        check("timeout_cfo_valid", CFO_DDS_inc_valid_o, 1);
      end
      n++;
    end
    check("timeout_seen", seen, 1);
  endtask

  task automatic mode_span_period();
    int cnt2, n;
    cnt2 = 0; n = 0;
    while (m_pos != SSB_PERIOD + PSS_WINDOW && n < 2 * SSB_PERIOD) begin
      step();
      if (PSS_detector_mode_o == 2'd2) cnt2++;
      n++;
    end
    check("mode2_span", cnt2, 2 * PSS_WINDOW + 1);
    step(1'b1, 1);
    check("close_edge_hit", state_o, S_TRACK);
  endtask

  task automatic miss_phase();
    int n, closes;
    bit seen, at_close, cv;
    n = 0; closes = 0; seen = 0;
    while (!seen && n < 4 * SSB_PERIOD) begin
      at_close = (m_state == S_TRACK) && (m_pos == SSB_PERIOD + PSS_WINDOW);
      cv = at_close && (closes == MAX_MISSES - 1);
      step(1'b0, 0, cv, 777, 1'b0, rnd_sv());
      if (at_close) begin
        closes++;
        if (closes < MAX_MISSES) check("miss_still_locked", locked_o, 1);
      end
      if (lost_sync_o) seen = 1;
      n++;
    end
    check("miss_lost_seen", seen, 1);
    check("miss_close_count", closes, MAX_MISSES);
    check("miss_state", state_o, S_SEARCH);
    check("miss_unlocked", locked_o, 0);
    check("clear_beats_cfo", CFO_DDS_inc_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_i = 1'b1;
    sample_valid_i = 0; N_id_2_valid_i = 0; N_id_2_i = 0;
    CFO_valid_i = 0; CFO_DDS_inc_i = 0; N_id_valid_i = 0;
    #3;
    check("rst_state", state_o, 0);
    check("rst_mode",  PSS_detector_mode_o, 0);
    check("rst_cfo",   CFO_DDS_inc_o, 0);
    check("rst_locked", locked_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // First PSS with a simultaneous CFO estimate.
    step(1'b1, 2, 1'b1, 100);
    check("pss_state", state_o, S_WAIT);
    check("pss_req",   requested_N_id_2_o, 2);
    check("pss_mode",  PSS_detector_mode_o, 1);
    check("pss_cfo",   CFO_DDS_inc_o, -100);
    check("pss_cfo_valid", CFO_DDS_inc_valid_o, 1);
    step();
    check("cfo_valid_one_cycle", CFO_DDS_inc_valid_o, 0);

    timeout_phase();

    // SSS confirmation arriving on the timeout cycle wins.
    step(1'b1, 1);
    run_to_pos(SSS_TIMEOUT, 1'b0);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    check("nid_beats_timeout", state_o, S_TRACK);
    check("nid_locked", locked_o, 1);
    check("nid_no_lost", lost_sync_o, 0);

    hit_at(int'($urandom_range(0, 20)) - 10);
    hit_at(-PSS_WINDOW);
    mode_span_period();
    run_to_pos(SSB_PERIOD - PSS_WINDOW - 1, 1'b0);
    step(1'b1, 3);
    check("outside_pss_ignored", m_pos != 0 && state_o == S_TRACK, 1);
    hit_at(0);
    hit_at(int'($urandom_range(0, 20)) - 10);

    miss_phase();

    // Saturation in both directions.
    repeat (3) step(1'b0, 0, 1'b1, -(1 << 19), 1'b0, 1'b0);
    check("sat_pos", CFO_DDS_inc_o, SAT);
    repeat (3) step(1'b0, 0, 1'b1, (1 << 19) - 1, 1'b0, 1'b0);
    check("sat_neg", CFO_DDS_inc_o, -SAT);
    step(1'b0, 0, 1'b1, -(1 << 19), 1'b0, 1'b1);
    check("sat_recover", CFO_DDS_inc_o, 1);

    // Asynchronous reset in the middle of tracking.
    step(1'b1, 3, 1'b1, -50);
    repeat (20) step();
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    repeat (50) step();
    check("pre_reset_track", state_o, S_TRACK);
    #2 reset_i = 1'b1;
    #1;
    check("async_state",  state_o, 0);
    check("async_mode",   PSS_detector_mode_o, 0);
    check("async_req",    requested_N_id_2_o, 0);
    check("async_cfo",    CFO_DDS_inc_o, 0);
    check("async_valid",  CFO_DDS_inc_valid_o, 0);
    check("async_locked", locked_o, 0);
    check("async_lost",   lost_sync_o, 0);
    hold_reset();

    step(1'b1, 1, 1'b1, 1234);
    repeat (10) step();
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    hit_at(int'($urandom_range(0, 20)) - 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_ctrl.md
Name: sync_ctrl

Overview:
- Sequences the receiver synchronisation loop: initial PSS search, SSS confirmation, then windowed PSS tracking with loss-of-sync detection.
- Drives the PSS detector mode and requested N_id_2.
- Owns the accumulated CFO increment fed to the CFO-correction DDS.
- Sits between PSS_detector, SSS_detector and the DDS phase accumulator. Replaces the ad-hoc mode/CFO logic spread across frame_sync and the top level.

Parameters:
- CFO_DW, 20, width of the signed relative CFO increment from the PSS detector.
- DDS_DW, 20, width of the signed accumulated DDS increment output.
- SSB_PERIOD, 38400, nominal PSS-to-PSS distance in decimated samples.
- PSS_WINDOW, 16, half-width of the tracking window in samples. Must be < SSB_PERIOD/2.
- SSS_TIMEOUT, 4096, samples allowed between PSS detection and N_id_valid_i.
- MAX_MISSES, 3, consecutive missed PSS windows before sync is declared lost. Must be ≥ 1.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- sample_valid_i  in  1  decimated sample strobe (CIC output tvalid); advances the sample counter
- N_id_2_valid_i  in  1  PSS detected pulse
- N_id_2_i  in  2  detected N_id_2, valid with N_id_2_valid_i
- CFO_valid_i  in  1  CFO estimate pulse
- CFO_DDS_inc_i  in  CFO_DW  signed CFO increment, relative to current correction
- N_id_valid_i  in  1  SSS decode success pulse
- PSS_detector_mode_o  out  2  0 = search all, 1 = disabled, 2 = track requested only
- requested_N_id_2_o  out  2  N_id_2 to track
- CFO_DDS_inc_o  out  DDS_DW  signed accumulated DDS increment
- CFO_DDS_inc_valid_o  out  1  one-cycle pulse when CFO_DDS_inc_o changes
- locked_o  out  1  high in TRACK
- lost_sync_o  out  1  one-cycle pulse on TRACK->SEARCH or WAIT_SSS timeout
- state_o  out  2  0 = SEARCH, 1 = WAIT_SSS, 2 = TRACK

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation): state SEARCH, mode 0, all other outputs 0, sample counter and miss counter 0.
- All outputs registered. Response appears 1 clk after the causing input.
- Sample counter cnt, width $clog2(SSB_PERIOD+PSS_WINDOW+1), increments on sample_valid_i only.

SEARCH:
- mode 0.
- On N_id_2_valid_i: latch N_id_2_i into requested_N_id_2_o, cnt <= 0, go to WAIT_SSS.

WAIT_SSS:
- mode 1. Further PSS pulses are ignored.
- On N_id_valid_i: go to TRACK, locked_o <= 1, miss count 0. cnt keeps running, so tracking is referenced to the initial PSS.
- If cnt reaches SSS_TIMEOUT first: go to SEARCH, pulse lost_sync_o.
- If N_id_valid_i and the timeout occur in the same cycle, N_id_valid_i wins.

TRACK:
- mode = 2 while SSB_PERIOD-PSS_WINDOW ≤ cnt ≤ SSB_PERIOD+PSS_WINDOW; else mode 1.
- N_id_2_valid_i inside the window: cnt <= 0, miss count <= 0.
- N_id_2_valid_i outside the window: ignored.
- cnt == SSB_PERIOD+PSS_WINDOW without a PSS: miss count +1 and cnt <= PSS_WINDOW, which re-aligns to the nominal grid.
  - If the miss count reaches MAX_MISSES: go to SEARCH, locked_o <= 0, pulse lost_sync_o.
- A PSS in the same cycle as the window-close edge counts as a hit.

CFO accumulation:
- On CFO_valid_i in any state: CFO_DDS_inc_o <= CFO_DDS_inc_o - sign_extend(CFO_DDS_inc_i), then pulse CFO_DDS_inc_valid_o.
- Result saturates to ±(2^(DDS_DW-1)-1).
- On entry to SEARCH after lost sync: CFO_DDS_inc_o <= 0 and CFO_DDS_inc_valid_o pulses.
- If CFO_valid_i coincides with that entry, the clear wins and the estimate is dropped.

Test Plan:
- Reset, then PSS N_id_2 = 2 with CFO_DDS_inc_i = 100 -> state 1, requested 2, mode 1, CFO_DDS_inc_o = -100 with 1-cycle valid pulse.
- WAIT_SSS with no N_id_valid_i for 4096 samples -> state 0, mode 0, lost_sync_o pulse, CFO_DDS_inc_o = 0.
- Lock; PSS every 38400 samples with ±10 jitter -> stays TRACK; mode 2 exactly for cnt 38384..38416; misses stay 0.
- Lock, then stop PSS -> miss count 1, 2, 3 at window closes; SEARCH with lost_sync_o after the third miss.
- Repeated CFO_DDS_inc_i = -2^19 -> CFO_DDS_inc_o saturates at 524287, no wrap. Assert reset_i mid-TRACK -> all outputs 0 immediately, no clock edge needed.
